// File: rtl/peak_frame_streamer_pkg.sv
// Shared defaults and types for the peak frame streamer slice.
package peak_frame_streamer_pkg;

    localparam int unsigned NP_DEF        = 16;
    localparam int unsigned PIXEL_NUM_DEF = 200;
    localparam int unsigned PIX_W_DEF     = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    typedef logic [NP_DEF-1:0] peak_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/peak_frame_streamer.sv
// Snapshots a frame of per-pixel peaks and streams it out one pixel per beat.
module peak_frame_streamer
    import peak_frame_streamer_pkg::*;
#(
    parameter int unsigned NP        = NP_DEF,
    parameter int unsigned PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned FID_W     = 8,
    parameter int unsigned DROP_W    = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    frame_done,
    input  logic [NP*PIXEL_NUM-1:0] peak_in,
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic [NP-1:0]           m_data,
    output logic [PIX_W-1:0]        m_pixel,
    output logic [FID_W-1:0]        m_frame,
    output logic                    m_last,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    overflow
);

    localparam int unsigned IDX_W = $clog2(PIXEL_NUM);
    localparam logic [0:0]  S_IDLE   = IDLE;
    localparam logic [0:0]  S_STREAM = STREAM;

    logic [0:0]       state_q;
    logic [0:0]       state_nxt;
    logic             valid_nxt;
    logic [NP-1:0]    data_nxt;
    logic [PIX_W-1:0] pixel_nxt;
    logic [FID_W-1:0] frame_nxt;
    logic [PIX_W-1:0] nxt_idx_c;
    logic             capture_c;
    logic             xfer_c;
    logic             drop_inc_c;
    logic [NP-1:0]    buf_q [PIXEL_NUM];

    assign xfer_c     = m_valid && m_ready;
    assign nxt_idx_c  = m_pixel + PIX_W'(1);
    assign drop_inc_c = frame_done && (state_q == S_STREAM);
    assign m_last     = m_valid && (m_pixel == PIX_W'(PIXEL_NUM - 1));
    assign busy       = (state_q == S_STREAM);

    // Next-state and next-beat selection; the next pixel is prefetched into m_data.
    always_comb begin
        state_nxt = state_q;
        valid_nxt = m_valid;
        data_nxt  = m_data;
        pixel_nxt = m_pixel;
        frame_nxt = m_frame;
        capture_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (frame_done) begin
                state_nxt = S_STREAM;
                capture_c = 1'b1;
                valid_nxt = 1'b1;
                pixel_nxt = '0;
                data_nxt  = peak_in[0 +: NP];
            end
        end else if (xfer_c) begin
            if (m_last) begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
                pixel_nxt = '0;
                data_nxt  = '0;
                frame_nxt = m_frame + FID_W'(1);
            end else begin
                pixel_nxt = nxt_idx_c;
                data_nxt  = buf_q[IDX_W'(nxt_idx_c)];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= S_IDLE;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_pixel  <= '0;
            m_frame  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            m_valid  <= valid_nxt;
            m_data   <= data_nxt;
            m_pixel  <= pixel_nxt;
            m_frame  <= frame_nxt;
            overflow <= overflow | drop_inc_c;
        end
    end

    // Frame snapshot; contents are only meaningful while streaming.
    always_ff @(posedge clk) begin
        if (capture_c) begin
            for (int p = 0; p < int'(PIXEL_NUM); p++) begin
                buf_q[p] <= peak_in[p*NP +: NP];
            end
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .clr_n (res),
        .inc   (drop_inc_c),
        .cnt   (drop_cnt)
    );

endmodule

// File: tb/tb_peak_frame_streamer.sv
// Directed table-driven bench for peak_frame_streamer (4 pixels x 8 bits).
module tb_peak_frame_streamer;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        frame_done = 1'b0;
    logic [31:0] peak_in = '0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_pixel;
    logic [1:0]  m_frame;
    logic        m_last;
    logic        busy;
    logic [1:0]  drop_cnt;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    peak_frame_streamer #(
        .NP        (8),
        .PIXEL_NUM (4),
        .PIX_W     (2),
        .FID_W     (2),
        .DROP_W    (2)
    ) dut (
        .clk        (clk),
        .res        (res),
        .frame_done (frame_done),
        .peak_in    (peak_in),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_pixel    (m_pixel),
        .m_frame    (m_frame),
        .m_last     (m_last),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    typedef struct {
        logic        res, fd, rdy;
        logic [31:0] peak;
        logic        v;
        logic [7:0]  d;
        logic [1:0]  pix, fr;
        logic        last, busy;
        logic [1:0]  drop;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic f, logic rd, logic [31:0] pk,
                                logic v, logic [7:0] d, logic [1:0] px, logic [1:0] fr,
                                logic l, logic b, logic [1:0] dc, logic o);
        vec_t t;
        t.res = r; t.fd = f; t.rdy = rd; t.peak = pk;
        t.v = v; t.d = d; t.pix = px; t.fr = fr;
        t.last = l; t.busy = b; t.drop = dc; t.ovf = o;
        return t;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [4];
        int beats;
        int cyc;

        // res fd rdy peak | valid data pix frame last busy drop ovf
        vecs.push_back(mk(0,0,0,32'h0,        0,8'h00,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,32'h44332211, 1,8'h11,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h22,1,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h33,2,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h44,3,0,1,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        0,8'h00,0,1,0,0,0,0));
        // stalls with ready 0/1 pattern
        vecs.push_back(mk(1,1,0,32'h44332211, 1,8'h11,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h22,1,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,32'h0,        1,8'h22,1,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,32'h0,        1,8'h22,1,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h33,2,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,32'h0,        1,8'h33,2,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h44,3,1,1,1,0,0));
        vecs.push_back(mk(1,0,0,32'h0,        1,8'h44,3,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        0,8'h00,0,2,0,0,0,0));
        // frame_done mid-stream is dropped
        vecs.push_back(mk(1,1,1,32'h88776655, 1,8'h55,0,2,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h66,1,2,0,1,0,0));
        vecs.push_back(mk(1,1,1,32'hAAAAAAAA, 1,8'h77,2,2,0,1,1,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h88,3,2,1,1,1,1));
        vecs.push_back(mk(1,0,1,32'h0,        0,8'h00,0,3,0,0,1,1));
        vecs.push_back(mk(1,1,1,32'hDDCCBBAA, 1,8'hAA,0,3,0,1,1,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'hBB,1,3,0,1,1,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'hCC,2,3,0,1,1,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'hDD,3,3,1,1,1,1));
        // frame_done on the last-beat transfer is dropped, frame id wraps
        vecs.push_back(mk(1,1,1,32'hEEEEEEEE, 0,8'h00,0,0,0,0,2,1));
        // frame_done right after the last beat is accepted
        vecs.push_back(mk(1,1,1,32'h04030201, 1,8'h01,0,0,0,1,2,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h02,1,0,0,1,2,1));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h03,2,0,0,1,2,1));
        // reset mid-stream
        vecs.push_back(mk(0,0,1,32'h0,        0,8'h00,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,32'h44332211, 1,8'h11,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h22,1,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h33,2,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        1,8'h44,3,0,1,1,0,0));
        vecs.push_back(mk(1,0,1,32'h0,        0,8'h00,0,1,0,0,0,0));

        foreach (vecs[i]) begin
            res        = vecs[i].res;
            frame_done = vecs[i].fd;
            m_ready    = vecs[i].rdy;
            peak_in    = vecs[i].peak;
            tick();
            chk($sformatf("v%0d m_valid", i),  int'(m_valid),  int'(vecs[i].v));
            chk($sformatf("v%0d m_data", i),   int'(m_data),   int'(vecs[i].d));
            chk($sformatf("v%0d m_pixel", i),  int'(m_pixel),  int'(vecs[i].pix));
            chk($sformatf("v%0d m_frame", i),  int'(m_frame),  int'(vecs[i].fr));
            chk($sformatf("v%0d m_last", i),   int'(m_last),   int'(vecs[i].last));
            chk($sformatf("v%0d busy", i),     int'(busy),     int'(vecs[i].busy));
            chk($sformatf("v%0d drop_cnt", i), int'(drop_cnt), int'(vecs[i].drop));
            chk($sformatf("v%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
        end

        // Stalled stream absorbing five dropped frames: drop_cnt saturates at 3.
        exp_b[0] = 8'h0A; exp_b[1] = 8'h0B; exp_b[2] = 8'h0C; exp_b[3] = 8'h0D;
        frame_done = 1'b1;
        m_ready    = 1'b0;
        peak_in    = 32'h0D0C0B0A;
        tick();
        chk("sat accept m_valid", int'(m_valid), 1);
        chk("sat accept m_frame", int'(m_frame), 1);
        for (int k = 1; k <= 5; k++) begin
            frame_done = 1'b1;
            peak_in    = 32'hFFFFFFFF;
            tick();
            chk($sformatf("sat drop%0d drop_cnt", k), int'(drop_cnt), (k > 3) ? 3 : k);
            chk($sformatf("sat drop%0d overflow", k), int'(overflow), 1);
            chk($sformatf("sat drop%0d m_data", k),   int'(m_data),   8'h0A);
            chk($sformatf("sat drop%0d m_pixel", k),  int'(m_pixel),  0);
        end
        frame_done = 1'b0;
        m_ready    = 1'b1;
        beats      = 0;
        cyc        = 0;
        while (m_valid && cyc < 20) begin
            if (beats < 4) begin
                chk($sformatf("drain beat%0d m_data", beats), int'(m_data), int'(exp_b[beats]));
                chk($sformatf("drain beat%0d m_pixel", beats), int'(m_pixel), beats);
                chk($sformatf("drain beat%0d m_last", beats), int'(m_last), (beats == 3) ? 1 : 0);
            end
            beats++;
            cyc++;
            tick();
        end
        chk("drain beat count", beats, 4);
        chk("drain m_valid", int'(m_valid), 0);
        chk("drain busy", int'(busy), 0);
        chk("drain m_frame", int'(m_frame), 2);
        chk("drain drop_cnt", int'(drop_cnt), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_frame_streamer.md
Name: peak_frame_streamer

Overview:
- Downstream neighbour of the histogram builder / peak detector.
- On a frame-done strobe, snapshots the per-pixel peak timestamps into a local buffer.
- Streams the snapshot out one pixel per beat on a valid/ready interface, tagged with pixel index, frame id and last-beat flag.
- Decouples the builder's one-shot parallel result from a slower serial consumer (readout FIFO / host link) and counts frames dropped while a stream is in progress.

Parameters:
- NP, 16, peak timestamp width in bits (matches `Np).
- PIXEL_NUM, 200, pixels per frame (matches `PIXEL_NUM_PER_RAM); must be >= 2.
- PIX_W, 8, pixel index width; must satisfy 2**PIX_W >= PIXEL_NUM.
- FID_W, 8, frame id counter width.
- DROP_W, 8, dropped-frame counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  synchronous active-low reset.
- frame_done  in  1  one-cycle strobe: peak_in is valid this cycle.
- peak_in  in  NP*PIXEL_NUM  flattened peaks; pixel p occupies bits [p*NP +: NP].
- m_ready  in  1  consumer accepts the beat.
- m_valid  out  1  beat available.
- m_data  out  NP  peak timestamp of the current pixel.
- m_pixel  out  PIX_W  current pixel index.
- m_frame  out  FID_W  frame id of the frame being streamed.
- m_last  out  1  high on the beat with m_pixel == PIXEL_NUM-1.
- busy  out  1  high while in STREAM.
- drop_cnt  out  DROP_W  saturating count of discarded frames.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (res==0 sampled at clk edge):
  - State goes to IDLE.
  - All outputs are 0, including m_frame, drop_cnt and overflow.
  - The buffer contents are don't-care.
  - Reset takes priority over every other event, including mid-stream; a partial stream is abandoned with no further beats.
- FSM states: IDLE and STREAM.
- IDLE:
  - frame_done=1 copies all of peak_in into the buffer.
  - Next cycle: m_valid=1, m_pixel=0, m_data=buf[0], m_frame=current frame id.
  - Go to STREAM. Latency from strobe to first valid is 1 cycle.
- STREAM beat rules:
  - A beat transfers when m_valid && m_ready.
  - While m_ready=0, m_data/m_pixel/m_last/m_frame hold stable and m_valid stays 1 (AXI-style; no valid drop).
  - On transfer with m_pixel < PIXEL_NUM-1: m_pixel increments and m_data = buf[m_pixel+1] the next cycle. Full throughput is 1 beat/cycle.
  - On transfer with m_last=1: m_valid=0, m_pixel=0, the frame id increments modulo 2**FID_W, and the FSM returns to IDLE the next cycle.
- m_last is combinational: m_valid && (m_pixel == PIXEL_NUM-1).
- busy = (state == STREAM).
- frame_done while in STREAM, including the last-beat transfer cycle:
  - The new frame is discarded; the buffer is untouched.
  - drop_cnt increments, saturating at 2**DROP_W-1.
  - overflow is set. Dropped frames do not consume a frame id.
- frame_done in the cycle the FSM is in IDLE (including the cycle right after the last beat) is accepted. Minimum gap between accepted frames is PIXEL_NUM+1 cycles.
- Width rules: no arithmetic on data, a pure copy. Index and counters are unsigned; the frame id wraps and drop_cnt saturates.
- Buffer: PIXEL_NUM x NP registers. Read mux is indexed by m_pixel; a registered output (next-index prefetch) is allowed if the timing above is preserved.

Decomposition:
- Shared package holds:
  - NP / PIXEL_NUM / PIX_W defaults, consistent with parametersSiFH.vh values;
  - state enum {IDLE, STREAM};
  - a typedef for the peak word (logic [NP-1:0]).
- One natural sub-module: sat_counter (parameterised width, inc, sync active-low clear), used for drop_cnt.
- Buffer, FSM and index counter stay inline.

Test Plan (bench overrides PIXEL_NUM=4, NP=8 unless stated):
- Reset then frame_done with peaks {0x11,0x22,0x33,0x44}, m_ready=1 -> m_valid rises 1 cycle later; beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles with m_pixel 0..3, m_last only on 0x44, m_frame=0; then m_valid=0, busy=0.
- Same frame with m_ready toggling 1,0,0,1,... -> no beat lost or duplicated; outputs stable during stalls; total beats=4.
- Second frame_done during beat 2 with peaks {0xAA..} -> stream continues with first frame data; drop_cnt=1, overflow=1; next accepted frame has m_frame=1.
- frame_done in the cycle right after m_last transfer -> accepted; m_valid=1 the following cycle with m_frame incremented.
- res=0 asserted mid-stream at pixel 2 -> next cycle m_valid=0, m_pixel=0, m_frame=0, drop_cnt=0, overflow=0; a later frame streams from pixel 0.
- DROP_W=2, 5 drops -> drop_cnt saturates at 3; FID_W=2 with 5 accepted frames -> m_frame sequence 0,1,2,3,0.
